// File: rtl/sample_mem_arbiter.sv
// Three-requester arbiter in front of a single-port synchronous sample memory:
// fixed priority for audio capture, bounded by a starvation counter, round-robin between the other two.
module sample_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [3:0]        len1,
    input  logic              req2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [3:0]        len2,
    output logic [2:0]        gnt,
    output logic [2:0]        ack,
    output logic [2:0]        done,
    output logic [2:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state, state_nxt;
    logic [2:0]          owner_q;
    logic [ADDR_W-1:0]   base_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          len_q;
    logic [3:0]          beat_q;
    logic [STARVE_W-1:0] starve_cnt;
    logic                rr_ptr;      // 0: requester 1 is next, 1: requester 2 is next
    logic [2:0]          rvalid_q;

    logic any_req, other_req, starved, pick0, pick1, pick2, last_beat;

    assign any_req   = req0 | req1 | req2;
    assign other_req = req1 | req2;
    assign starved   = (starve_cnt == STARVE_W'(STARVE_MAX)) && other_req;
    assign pick0     = req0 && !starved;
    assign pick1     = !pick0 && req1 && (!req2 || !rr_ptr);
    assign pick2     = !pick0 && req2 && (!req1 || rr_ptr);
    assign last_beat = (beat_q == len_q);

    assign rvalid = rvalid_q;
    assign rdata  = memRData;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output gets a default first, so no path through this block
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        gnt       = 3'b000;
        ack       = 3'b000;
        done      = 3'b000;
        memEn     = 1'b0;
        memWe     = 1'b0;
        memAddr   = '0;
        memWData  = '0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = BURST;
            end
            BURST: begin
                gnt      = owner_q;
                ack      = owner_q;
                done     = last_beat ? owner_q : 3'b000;
                memEn    = 1'b1;
                memWe    = we_q;
                memAddr  = base_q + ADDR_W'(beat_q);
                memWData = wdata_q;
                if (last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            owner_q    <= 3'b000;
            base_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            starve_cnt <= '0;
            rr_ptr     <= 1'b0;
            rvalid_q   <= 3'b000;
        end else begin
            // Read data returns one cycle after its beat, even once back in IDLE.
            rvalid_q <= (state == BURST && !we_q) ? owner_q : 3'b000;
            if (state == IDLE) begin
                beat_q <= '0;
                if (pick0) begin
                    owner_q <= 3'b001;
                    base_q  <= addr0;
                    we_q    <= 1'b1;
                    wdata_q <= wdata0;
                    len_q   <= '0;
                end else if (pick1) begin
                    owner_q <= 3'b010;
                    base_q  <= addr1;
                    we_q    <= we1;
                    wdata_q <= wdata1;
                    len_q   <= len1;
                    rr_ptr  <= 1'b1;
                end else if (pick2) begin
                    owner_q <= 3'b100;
                    base_q  <= addr2;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    len_q   <= len2;
                    rr_ptr  <= 1'b0;
                end
                // Outside a grant to 0 with others waiting, the counter always clears.
                if (pick0 && other_req) begin
                    if (starve_cnt != STARVE_W'(STARVE_MAX))
                        starve_cnt <= starve_cnt + STARVE_W'(1);
                end else begin
                    starve_cnt <= '0;
                end
            end else begin
                beat_q <= beat_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sample_mem_arbiter.sv
// Directed bench for sample_mem_arbiter: outputs are sampled on the falling edge,
// inputs are changed there too, and expected values are hand-derived per scenario.
module tb_sample_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, req2 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, addr2 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic [3:0]  len1 = '0, len2 = '0;
    logic [2:0]  gnt, ack, done, rvalid;
    logic [15:0] rdata, memAddr, memWData;
    logic [15:0] memRData = '0;
    logic        memEn, memWe;

    int checks   = 0;
    int failures = 0;

    sample_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req0(req0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .len1(len1),
        .req2(req2), .addr2(addr2), .len2(len2),
        .gnt(gnt), .ack(ack), .done(done), .rvalid(rvalid), .rdata(rdata),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Synchronous memory model: read data appears the cycle after the command.
    always @(posedge CLK) if (memEn && !memWe) memRData <= mem_word(memAddr);

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic do_reset;
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        req1 = 1'b1; addr1 = 16'h1234; len1 = 4'd2;
        tick();
        tick();
        checks++;
        if ({gnt, ack, done, rvalid} !== 12'h000) begin
            failures++;
            $display("FAIL reset_handshake got=%b_%b_%b_%b exp=000_000_000_000", gnt, ack, done, rvalid);
        end
        checks++;
        if ({memEn, memWe, memAddr, memWData} !== 34'h0) begin
            failures++;
            $display("FAIL reset_mem got en=%b we=%b addr=%h wdata=%h exp all zero", memEn, memWe, memAddr, memWData);
        end
        req1 = 1'b0;
        RESET_N = 1'b1;
        tick();
        tick();
        checks++;
        if (memEn !== 1'b0 || gnt !== 3'b000) begin
            failures++;
            $display("FAIL idle_no_req got en=%b gnt=%b exp en=0 gnt=000", memEn, gnt);
        end
    endtask

    task automatic test_single_read;
        logic [15:0] exp_addr;
        we1 = 1'b0; addr1 = 16'h0100; len1 = 4'd3; req1 = 1'b1;
        tick();
        req1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_addr = 16'h0100 + 16'(k);
            checks++;
            if ({gnt, ack, memEn, memWe, memAddr} !== {3'b010, 3'b010, 1'b1, 1'b0, exp_addr}) begin
                failures++;
                $display("FAIL single_beat%0d got gnt=%b ack=%b en=%b we=%b addr=%h exp gnt=010 ack=010 en=1 we=0 addr=%h",
                         k, gnt, ack, memEn, memWe, memAddr, exp_addr);
            end
            checks++;
            if (done !== ((k == 3) ? 3'b010 : 3'b000)) begin
                failures++;
                $display("FAIL single_done%0d got=%b", k, done);
            end
            if (k > 0) begin
                checks++;
                if (rvalid !== 3'b010 || rdata !== mem_word(exp_addr - 16'd1)) begin
                    failures++;
                    $display("FAIL single_rvalid%0d got rvalid=%b rdata=%h exp rvalid=010 rdata=%h",
                             k, rvalid, rdata, mem_word(exp_addr - 16'd1));
                end
            end else begin
                checks++;
                if (rvalid !== 3'b000) begin
                    failures++;
                    $display("FAIL single_rvalid0 got=%b exp=000", rvalid);
                end
            end
            tick();
        end
        checks++;
        if (gnt !== 3'b000 || memEn !== 1'b0 || rvalid !== 3'b010 || rdata !== mem_word(16'h0103)) begin
            failures++;
            $display("FAIL single_tail got gnt=%b en=%b rvalid=%b rdata=%h exp gnt=000 en=0 rvalid=010 rdata=%h",
                     gnt, memEn, rvalid, rdata, mem_word(16'h0103));
        end
        tick();
        checks++;
        if (rvalid !== 3'b000) begin
            failures++;
            $display("FAIL single_rvalid_clear got=%b exp=000", rvalid);
        end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_gnt [5];
        exp_gnt = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b010};
        do_reset();
        we1 = 1'b1; len1 = 4'd0; addr1 = 16'h0200; wdata1 = 16'h1111;
        addr2 = 16'h0210; len2 = 4'd0;
        req1 = 1'b1; req2 = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (gnt !== exp_gnt[i]) begin
                failures++;
                $display("FAIL rr_gnt%0d got=%b exp=%b", i, gnt, exp_gnt[i]);
            end
            if (i == 2) begin
                checks++;
                if (memAddr !== 16'h0210 || memWe !== 1'b0 || done !== 3'b100) begin
                    failures++;
                    $display("FAIL rr_req2_beat got addr=%h we=%b done=%b exp addr=0210 we=0 done=100", memAddr, memWe, done);
                end
            end
            if (i == 4) begin req1 = 1'b0; req2 = 1'b0; end
            tick();
        end
    endtask

    task automatic test_starvation;
        logic [2:0] exp_gnt [12];
        exp_gnt = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000,
                    3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b001};
        do_reset();
        req0 = 1'b1; addr0 = 16'h0040; wdata0 = 16'hA0A0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0500; wdata1 = 16'h5555; len1 = 4'd1;
        tick();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (gnt !== exp_gnt[i]) begin
                failures++;
                $display("FAIL starve_gnt%0d got=%b exp=%b", i, gnt, exp_gnt[i]);
            end
            if (i == 0) begin
                checks++;
                if ({memWe, memAddr, memWData, done} !== {1'b1, 16'h0040, 16'hA0A0, 3'b001}) begin
                    failures++;
                    $display("FAIL starve_req0_beat got we=%b addr=%h wdata=%h done=%b exp we=1 addr=0040 wdata=a0a0 done=001",
                             memWe, memAddr, memWData, done);
                end
            end
            if (i == 9) begin
                checks++;
                if ({memWe, memAddr, memWData, done} !== {1'b1, 16'h0501, 16'h5555, 3'b010}) begin
                    failures++;
                    $display("FAIL starve_req1_last got we=%b addr=%h wdata=%h done=%b exp we=1 addr=0501 wdata=5555 done=010",
                             memWe, memAddr, memWData, done);
                end
            end
            if (i == 11) begin req0 = 1'b0; req1 = 1'b0; end
            tick();
        end
    endtask

    task automatic test_wrap;
        logic [15:0] exp_addr [4];
        exp_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        addr2 = 16'hFFFE; len2 = 4'd3; req2 = 1'b1;
        tick();
        req2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({gnt, memWe, memAddr} !== {3'b100, 1'b0, exp_addr[k]}) begin
                failures++;
                $display("FAIL wrap_beat%0d got gnt=%b we=%b addr=%h exp gnt=100 we=0 addr=%h",
                         k, gnt, memWe, memAddr, exp_addr[k]);
            end
            if (k == 3) begin
                checks++;
                if (done !== 3'b100) begin
                    failures++;
                    $display("FAIL wrap_done got=%b exp=100", done);
                end
            end
            tick();
        end
        checks++;
        if (rvalid !== 3'b100 || rdata !== mem_word(16'h0001)) begin
            failures++;
            $display("FAIL wrap_rdata got rvalid=%b rdata=%h exp rvalid=100 rdata=%h", rvalid, rdata, mem_word(16'h0001));
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_addr;
        int          bad;
        bad = 0;
        we1 = 1'b1; addr1 = 16'h2000; wdata1 = 16'h2222; len1 = 4'd15; req1 = 1'b1;
        tick();
        req1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp_addr = 16'h2000 + 16'(k);
            if (gnt !== 3'b010 || memAddr !== exp_addr || memWData !== 16'h2222 ||
                done !== ((k == 15) ? 3'b010 : 3'b000)) begin
                bad++;
                $display("FAIL preempt_beat%0d got gnt=%b addr=%h wdata=%h done=%b exp gnt=010 addr=%h wdata=2222",
                         k, gnt, memAddr, memWData, done, exp_addr);
            end
            if (k == 1) begin
                req0 = 1'b1; addr0 = 16'h0040; wdata0 = 16'hBEEF; addr1 = 16'h7777;
            end
            tick();
        end
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (gnt !== 3'b000 || memEn !== 1'b0) begin
            failures++;
            $display("FAIL preempt_turnaround got gnt=%b en=%b exp gnt=000 en=0", gnt, memEn);
        end
        tick();
        checks++;
        if ({gnt, memWe, memAddr, memWData, done} !== {3'b001, 1'b1, 16'h0040, 16'hBEEF, 3'b001}) begin
            failures++;
            $display("FAIL preempt_req0 got gnt=%b we=%b addr=%h wdata=%h done=%b exp gnt=001 we=1 addr=0040 wdata=beef done=001",
                     gnt, memWe, memAddr, memWData, done);
        end
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_burst;
        bit seen_done;
        addr2 = 16'h0300; len2 = 4'd7; req2 = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 3'b100 || memAddr !== 16'h0302) begin
            failures++;
            $display("FAIL abort_third_beat got gnt=%b addr=%h exp gnt=100 addr=0302", gnt, memAddr);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({gnt, ack, done, rvalid, memEn, memWe, memAddr, memWData} !== 46'h0) begin
            failures++;
            $display("FAIL abort_outputs got gnt=%b ack=%b done=%b rvalid=%b en=%b we=%b addr=%h wdata=%h exp all zero",
                     gnt, ack, done, rvalid, memEn, memWe, memAddr, memWData);
        end
        tick();
        checks++;
        if ({done, rvalid, memEn} !== 7'h0) begin
            failures++;
            $display("FAIL abort_held got done=%b rvalid=%b en=%b exp 000/000/0", done, rvalid, memEn);
        end
        RESET_N = 1'b1;
        tick();
        checks++;
        if ({gnt, memAddr, rvalid} !== {3'b100, 16'h0300, 3'b000}) begin
            failures++;
            $display("FAIL abort_regrant got gnt=%b addr=%h rvalid=%b exp gnt=100 addr=0300 rvalid=000", gnt, memAddr, rvalid);
        end
        req2 = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (done == 3'b100) seen_done = 1'b1;
            tick();
        end
        checks++;
        if (!seen_done || gnt !== 3'b000) begin
            failures++;
            $display("FAIL abort_finish got done_seen=%0d gnt=%b exp done_seen=1 gnt=000", seen_done, gnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_starvation();
        test_wrap();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sample_mem_arbiter.md
SAMPLE_MEM_ARBITER -- requirements
Module: sample_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, sample memory address width.
REQ-002 Parameter DATA_W, default 16, sample word width.
REQ-003 Parameter STARVE_MAX, default 4, consecutive requester-0 grants allowed while requester 1 or 2 waits.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET_N  in  1  reset, asynchronous and active-low.
REQ-006 req0/addr0/wdata0  in  1/ADDR_W/DATA_W  requester 0, audio capture; write-only, single beat.
REQ-007 req1/we1/addr1/wdata1/len1  in  1/1/ADDR_W/DATA_W/4  requester 1, processing core; read or write burst of len1+1 beats.
REQ-008 req2/addr2/len2  in  1/ADDR_W/4  requester 2, audio playback; read-only burst of len2+1 beats.
REQ-009 gnt  out  3  one-hot owner of the current burst; 000 when idle.
REQ-010 ack  out  3  one-hot, high in each cycle a beat of the owner's burst is issued to memory.
REQ-011 done  out  3  one-hot, high together with ack on the final beat.
REQ-012 rvalid  out  3  one-hot, read data valid for the owner of the beat issued in the previous cycle.
REQ-013 rdata  out  DATA_W  copy of memRData, qualified by rvalid.
REQ-014 memEn/memWe/memAddr/memWData  out  1/1/ADDR_W/DATA_W  synchronous single-port memory command.
REQ-015 memRData  in  DATA_W  memory read data, valid the cycle after memEn with memWe=0.

Function
REQ-016 FSM states are IDLE and BURST only.
REQ-017 In IDLE with no req asserted, the block remains in IDLE and outputs memEn=0.
REQ-018 In IDLE with any req asserted, the block selects one owner, latches its base address, we, wdata and length (requester 0: len 0, we 1; requester 2: we 0), and enters BURST on the next edge; no memory beat is issued in the IDLE cycle.
REQ-019 Selection: requester 0 wins unless starveCnt equals STARVE_MAX and req1 or req2 is asserted; otherwise requester 1 or 2 wins, chosen round-robin.
REQ-020 The round-robin pointer starts at requester 1 and toggles to the other of 1/2 after each grant to 1 or 2; if only one of them is requesting, that one wins regardless of the pointer.
REQ-021 starveCnt increments (saturating at STARVE_MAX) on each grant to 0 while req1 or req2 is high, and clears on any grant to 1 or 2 or when neither req1 nor req2 is high in IDLE.
REQ-022 In BURST, exactly one beat per cycle: memEn=1, memAddr=base+beat, memWe=latched we, memWData=latched wdata, and ack for the owner is 1.
REQ-023 Address arithmetic is modulo 2^ADDR_W; base+beat wraps from all-ones to zero.
REQ-024 The beat counter runs 0..len; on beat==len, done is asserted and the FSM returns to IDLE on the next edge.
REQ-025 Requests are sampled only in IDLE; a requester dropping or changing req/addr during BURST does not alter the burst, and no requester can pre-empt a burst.
REQ-026 A read beat issued in cycle N asserts rvalid for that owner in cycle N+1, including the cycle after the final beat, even if a new arbitration is in progress in IDLE.
REQ-027 Minimum turnaround is one IDLE cycle between bursts; worst-case wait for requester 0 is 17 cycles after acceptance of a competing burst.

Reset
REQ-028 While RESET_N=0: state IDLE, gnt=ack=done=rvalid=000, memEn=0, memWe=0, memAddr=0, memWData=0, beat counter 0, starveCnt 0, round-robin pointer at requester 1.
REQ-029 Reset asserted mid-burst aborts the burst immediately: no done and no rvalid for the aborted beats; after release the block arbitrates afresh from IDLE.

Verification
REQ-030 Only req1 (we1=0, addr1=0x0100, len1=3) -> gnt=010 for 4 cycles, memAddr 0x0100..0x0103, done1 on the fourth beat, rvalid1 in the 4 cycles after each beat.
REQ-031 req1 and req2 asserted together from reset -> requester 1 served first, then requester 2; a repeat of both -> requester 1 again after 2.
REQ-032 req0 held continuously with req1 held, STARVE_MAX=4 -> four single-beat grants to 0, then one burst to 1, then requester 0 resumes.
REQ-033 req2 addr2=0xFFFE, len2=3 -> memAddr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-034 req0 asserted during the second beat of a 16-beat burst to requester 1 -> burst completes uninterrupted; requester 0 gets gnt after one IDLE cycle.
REQ-035 RESET_N pulsed low on the third beat of a burst -> all outputs zero immediately, no done; after release, a pending req is granted after one IDLE cycle.
